// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared types and constants for the PPU pixel mixer
package ppu_pkg;

  localparam int PPU_TILE_W    = 8;
  localparam int PPU_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISCARD,
    ST_RUN
  } ppu_state_e;

  typedef struct packed {
    logic [1:0] bg_idx;
    logic [1:0] obj_idx;
    logic       obj_pal;
    logic       obj_prio;
  } ppu_slot_t;

endpackage

// File: rtl/ppu_px_ring.sv
// rtl/ppu_px_ring.sv - pixel slot ring: 8-wide push, single pop, head window overlay
module ppu_px_ring
  import ppu_pkg::*;
#(
  parameter int DEPTH = PPU_DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            push,
  input  logic [PPU_TILE_W-1:0]           push_lo,
  input  logic [PPU_TILE_W-1:0]           push_hi,
  input  logic                            pop,
  input  logic [PPU_TILE_W-1:0]           ovl_we,
  input  logic [PPU_TILE_W-1:0][1:0]      ovl_idx,
  input  logic                            ovl_pal,
  input  logic                            ovl_prio,
  output ppu_slot_t                       head,
  output logic [PPU_TILE_W-1:0][1:0]      win_obj_idx,
  output logic [CNT_W-1:0]                count
);

  localparam int AW = $clog2(DEPTH);

  ppu_slot_t            mem_q [DEPTH];
  ppu_slot_t            mem_d [DEPTH];
  logic [AW-1:0]        head_q, head_d, tail;
  logic [CNT_W-1:0]     count_q, count_d;

  assign tail  = head_q + AW'(count_q);
  assign count = count_q;
  assign head  = mem_q[head_q];

  always_comb begin
    for (int k = 0; k < PPU_TILE_W; k++) begin
      win_obj_idx[k] = mem_q[head_q + AW'(k)].obj_idx;
    end
  end

  // Overlay targets head..head+7 and a push targets tail..tail+7; the
  // occupancy limits on each guarantee the two windows never overlap.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i].obj_idx  = 2'b00;
        mem_d[i].obj_pal  = 1'b0;
        mem_d[i].obj_prio = 1'b0;
      end
      count_d = '0;
    end else begin
      for (int k = 0; k < PPU_TILE_W; k++) begin
        if (ovl_we[k]) begin
          mem_d[head_q + AW'(k)].obj_idx  = ovl_idx[k];
          mem_d[head_q + AW'(k)].obj_pal  = ovl_pal;
          mem_d[head_q + AW'(k)].obj_prio = ovl_prio;
        end
      end
      if (push) begin
        for (int k = 0; k < PPU_TILE_W; k++) begin
          mem_d[tail + AW'(k)] = '{bg_idx:   {push_hi[PPU_TILE_W-1-k], push_lo[PPU_TILE_W-1-k]},
                                   obj_idx:  2'b00,
                                   obj_pal:  1'b0,
                                   obj_prio: 1'b0};
        end
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + (push ? CNT_W'(PPU_TILE_W) : '0) - (pop ? CNT_W'(1) : '0);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      head_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ppu_px_mixer.sv
// rtl/ppu_px_mixer.sv - BG/sprite pixel FIFO, line FSM and shade mixer
// Optional fine-scroll discard is enabled by defining PPU_FINE_SCROLL_EN.
module ppu_px_mixer
  import ppu_pkg::*;
#(
  parameter int DEPTH = PPU_DEPTH_DEF,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_start,
  input  logic [2:0]            scx_fine,
  input  logic [7:0]            bg_lo,
  input  logic [7:0]            bg_hi,
  input  logic                  bg_valid,
  output logic                  bg_ready,
  input  logic [7:0]            obj_lo,
  input  logic [7:0]            obj_hi,
  input  logic                  obj_load,
  input  logic                  obj_pal,
  input  logic                  obj_xflip,
  input  logic                  obj_prio,
  input  logic [7:0]            bgp,
  input  logic [7:0]            obp0,
  input  logic [7:0]            obp1,
  input  logic                  bg_en,
  input  logic                  obj_en,
  output logic [1:0]            px_out,
  output logic                  px_valid,
  input  logic                  px_ready,
  output logic [CNT_W-1:0]      count,
  output logic                  obj_drop
);

  localparam logic [CNT_W-1:0] TILE_CNT = CNT_W'(PPU_TILE_W);
  localparam logic [CNT_W-1:0] ROOM_CNT = CNT_W'(DEPTH - PPU_TILE_W);

  ppu_state_e                    state_q, state_d;
  logic [2:0]                    disc_q, disc_d;
  logic                          obj_drop_q, obj_drop_d;
  ppu_slot_t                     head;
  logic [PPU_TILE_W-1:0][1:0]    win_obj_idx;
  logic [PPU_TILE_W-1:0][1:0]    ovl_idx;
  logic [PPU_TILE_W-1:0]         ovl_we;
  logic                          push, pop, run_pop, disc_pop, ovl_ok, spr_win;
  logic [1:0]                    bge;
  logic [7:0]                    obj_pal_sel;

`ifndef PPU_FINE_SCROLL_EN
  logic unused_scx;
  assign unused_scx = ^scx_fine;
`endif

  assign bg_ready = (state_q != ST_IDLE) && (count <= ROOM_CNT);
  assign px_valid = (state_q == ST_RUN) && (count != '0) && !obj_load;
  assign run_pop  = px_valid && px_ready;
  assign disc_pop = (state_q == ST_DISCARD) && (count != '0) && (disc_q != 3'd0);
  assign push     = bg_valid && bg_ready && !line_start;
  assign pop      = (run_pop || disc_pop) && !line_start;
  assign ovl_ok   = obj_load && !line_start && (state_q != ST_IDLE) && (count >= TILE_CNT);
  assign obj_drop = obj_drop_q;

  // Earlier sprites keep their pixels: only transparent slots take a new index.
  always_comb begin
    for (int k = 0; k < PPU_TILE_W; k++) begin
      ovl_idx[k] = obj_xflip ? {obj_hi[k], obj_lo[k]}
                             : {obj_hi[PPU_TILE_W-1-k], obj_lo[PPU_TILE_W-1-k]};
      ovl_we[k]  = ovl_ok && (win_obj_idx[k] == 2'b00) && (ovl_idx[k] != 2'b00);
    end
  end

  always_comb begin
    state_d    = state_q;
    disc_d     = disc_q;
    obj_drop_d = 1'b0;
    if (line_start) begin
`ifdef PPU_FINE_SCROLL_EN
      disc_d = scx_fine;
`else
      disc_d = 3'd0;
`endif
      state_d = (disc_d != 3'd0) ? ST_DISCARD : ST_RUN;
    end else begin
      obj_drop_d = obj_load && ((state_q == ST_IDLE) || (count < TILE_CNT));
      if (disc_pop) begin
        disc_d = disc_q - 3'd1;
        if (disc_q == 3'd1) begin
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      disc_q     <= 3'd0;
      obj_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      disc_q     <= disc_d;
      obj_drop_q <= obj_drop_d;
    end
  end

  ppu_px_ring #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .flush       (line_start),
    .push        (push),
    .push_lo     (bg_lo),
    .push_hi     (bg_hi),
    .pop         (pop),
    .ovl_we      (ovl_we),
    .ovl_idx     (ovl_idx),
    .ovl_pal     (obj_pal),
    .ovl_prio    (obj_prio),
    .head        (head),
    .win_obj_idx (win_obj_idx),
    .count       (count)
  );

  assign bge         = bg_en ? head.bg_idx : 2'b00;
  assign spr_win     = obj_en && (head.obj_idx != 2'b00) && !(head.obj_prio && (bge != 2'b00));
  assign obj_pal_sel = head.obj_pal ? obp1 : obp0;
  assign px_out      = spr_win ? obj_pal_sel[{head.obj_idx, 1'b0} +: 2] : bgp[{bge, 1'b0} +: 2];

endmodule

// File: doc/ppu_px_mixer.md
PPU_PX_MIXER -- requirements
Module: ppu_px_mixer

Interface
REQ-001 Parameter DEPTH, default 16: pixel slots per FIFO; power of two, at least 16.
REQ-002 Parameter CNT_W, default $clog2(DEPTH+1): width of the occupancy count.
REQ-003 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 line_start  in  1  flush both FIFOs and begin a new scanline.
REQ-006 scx_fine  in  3  SCX[2:0], sampled on line_start.
REQ-007 bg_lo, bg_hi  in  8 each  BG tile-row bitplanes; bit7 is the leftmost pixel.
REQ-008 bg_valid  in  1 / bg_ready  out  1  BG 8-pixel push handshake.
REQ-009 obj_lo, obj_hi  in  8 each  sprite tile-row bitplanes.
REQ-010 obj_load  in  1  overlay one sprite row onto the 8 head slots.
REQ-011 obj_pal  in  1  OAM flag bit4; obj_xflip  in  1  flag bit5; obj_prio  in  1  flag bit7.
REQ-012 bgp, obp0, obp1  in  8 each  palettes; bg_en  in  1  LCDC[0]; obj_en  in  1  LCDC[1].
REQ-013 px_out  out  2  final shade; px_valid  out  1; px_ready  in  1  downstream accept.
REQ-014 count  out  CNT_W  occupied slots; obj_drop  out  1  one-cycle pulse when an overlay is rejected.

Function
REQ-015 Each slot holds bg_idx[1:0], obj_idx[1:0], obj_pal and obj_prio; storage is a ring with head pointer modulo DEPTH.
REQ-016 States: IDLE, DISCARD, RUN; reset enters IDLE.
REQ-017 line_start in any state zeroes count and all slot obj fields; next state is DISCARD if the latched discard count is nonzero, else RUN.
REQ-018 bg_ready = (state != IDLE) && (count <= DEPTH-8); a push writes 8 slots in order bit7..bit0 with bg_idx = {hi[i], lo[i]} and obj fields cleared.
REQ-019 A pop occurs when px_valid && px_ready; on simultaneous push and pop, count becomes count+7.
REQ-020 px_valid = (state == RUN) && (count != 0) && !obj_load.
REQ-021 In DISCARD, one slot is popped per cycle while count != 0, without asserting px_valid; reaching zero moves to RUN in the same cycle as the last discard.
REQ-022 obj_load with count >= 8: for each of the 8 head slots, new idx = {hi, lo} with bit order reversed when obj_xflip is set; the slot is written only if its current obj_idx == 0 and the new idx != 0 (earlier sprite wins).
REQ-023 obj_load with count < 8 or in IDLE is ignored and pulses obj_drop for one cycle.
REQ-024 Mix: bge = bg_en ? bg_idx : 0; the sprite wins if obj_en && obj_idx != 0 && !(obj_prio && bge != 0).
REQ-025 px_out = sprite wins ? (obj_pal ? obp1 : obp0)[2*obj_idx +: 2] : bgp[2*bge +: 2]; combinational from the head slot.
REQ-026 line_start has priority over push, pop and overlay in the same cycle.

Reset
REQ-027 rst clears: state IDLE, count 0, head 0, discard count 0, obj_drop 0; hence px_valid 0 and bg_ready 0.
REQ-028 rst mid-line discards all contents; no pixel is emitted until the next line_start.

Configuration
REQ-029 Macro PPU_FINE_SCROLL_EN: when defined, line_start latches discard count = scx_fine.
REQ-030 When PPU_FINE_SCROLL_EN is undefined, scx_fine is ignored, discard count is always 0 and DISCARD is unreachable.

Structure
REQ-031 Package ppu_pkg holds: the state enum typedef, the packed slot struct, and the constants PPU_TILE_W=8 and PPU_DEPTH_DEF=16.
REQ-032 Sub-module ppu_px_ring implements the ring storage, head/count and 8-wide push; ppu_px_mixer holds the FSM, overlay and mix logic.

Verification
REQ-033 Sequence: line_start (scx_fine=0); push lo=8'hF0, hi=8'h0F; bgp=8'hE4; px_ready=1. Expect px_out 1,1,1,1,2,2,2,2 on consecutive cycles, then px_valid=0.
REQ-034 PPU_FINE_SCROLL_EN defined: line_start with scx_fine=3, then push two rows. Expect 3 discard cycles, first emitted pixel = bit4 of the first row, 13 pixels total.
REQ-035 Overlay with obj_lo=8'h80, xflip=1, prio=0, obp0=8'hE4, on 8 BG pixels of idx 0. Expect only the 8th pixel = shade 1; a second overlay with 8'hFF changes only the other 7.
REQ-036 obj_prio=1, bg idx 2 under sprite idx 3. Expect the BG shade; with bg_en=0, expect the sprite shade.
REQ-037 DEPTH=16: push, push. Expect bg_ready=0 at count 16, pushing resumes after 8 pops. A simultaneous push and pop at count 8 gives count 15.
REQ-038 obj_load at count 4. Expect obj_drop pulse with no slot changed; rst mid-RUN gives px_valid=0 and count 0 on the next cycle.
